// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: function codes, FSM states and
// bit positions of the {s,z,c,v} condition code.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_SLR = 4'b1001;
  localparam logic [3:0] F_SRL = 4'b1010;
  localparam logic [3:0] F_SRA = 4'b1011;

  localparam int CODE_S = 3;
  localparam int CODE_Z = 2;
  localparam int CODE_C = 1;
  localparam int CODE_V = 0;

  function automatic logic is_legal(input logic [3:0] f);
    return (f & 4'b1100) == 4'b1000;
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-pass shifter: moves 'in' by k (0..STEP_MAX) positions
// through a binary-weighted mux chain and reports the last bit out and overflow.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int STEP_MAX = 8,
  parameter int WIDTH    = 16,
  localparam int KW      = $clog2(STEP_MAX) + 1
) (
  input  logic [3:0]       fcode,
  input  logic [KW-1:0]    k,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             vstep
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] mask;
  logic             left;

  always_comb begin
    data = in;
    for (int s = 0; s < KW; s++) begin
      if (k[s]) begin
        case (fcode)
          F_SLL:   data = data << (1 << s);
          F_SRL:   data = data >> (1 << s);
          F_SRA:   data = $unsigned($signed(data) >>> (1 << s));
          F_SLR:   data = (data << (1 << s)) | (data >> (WIDTH - (1 << s)));
          default: data = data;
        endcase
      end
    end
    out = data;
  end

  // Last bit leaving the word: in[WIDTH-k] for left moves, in[k-1] for right.
  always_comb begin
    left = (fcode == F_SLL) || (fcode == F_SLR);
    cout = 1'b0;
    for (int i = 1; i <= STEP_MAX; i++) begin
      if (int'(k) == i) cout = left ? in[WIDTH-i] : in[i-1];
    end
  end

  // Overflow: the top k+1 bits are not all equal, so bit 15 flips during the pass.
  always_comb begin
    mask = '0;
    for (int j = 0; j < WIDTH; j++) begin
      mask[j] = (j >= WIDTH - 1 - int'(k));
    end
    vstep = ((in & mask) != '0) && ((in & mask) != mask);
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass shift controller: accepts one request, runs the step unit until the
// amount is consumed (first pass on the accept edge) and holds the response.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP_MAX = 8,
  parameter int WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_fcode,
  input  logic [4:0]       req_shift,
  input  logic [WIDTH-1:0] req_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       code,
  output logic             err,
  output state_t           dbg_state
);

  localparam int KW = $clog2(STEP_MAX) + 1;
  localparam logic [4:0] STEP_MAX_W = 5'(STEP_MAX);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds with its payload stable until taken.
  state_t           state;
  logic [3:0]       fcode_q;
  logic [4:0]       rem;
  logic [WIDTH-1:0] work;
  logic             c_q, v_q;

  logic             accept, advance;
  logic [3:0]       step_fcode;
  logic [4:0]       step_rem, rem_next;
  logic [WIDTH-1:0] step_in, step_out;
  logic [KW-1:0]    k;
  logic             step_cout, step_v, c_new, v_new;
  logic [3:0]       code_n;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign result    = work;
  assign dbg_state = state;

  // While idle the step unit works directly on the request fields.
  assign step_fcode = (state == IDLE) ? req_fcode : fcode_q;
  assign step_rem   = (state == IDLE) ? req_shift : rem;
  assign step_in    = (state == IDLE) ? req_in    : work;
  assign k          = (step_rem > STEP_MAX_W) ? KW'(STEP_MAX) : KW'(step_rem);
  assign rem_next   = step_rem - 5'(k);
  assign advance    = (state == RUN) || (accept && is_legal(req_fcode));

  shift_step_unit #(
    .STEP_MAX (STEP_MAX),
    .WIDTH    (WIDTH)
  ) u_step (
    .fcode (step_fcode),
    .k     (k),
    .in    (step_in),
    .out   (step_out),
    .cout  (step_cout),
    .vstep (step_v)
  );

  assign c_new = (k != '0) && step_cout;
  assign v_new = ((state == RUN) && v_q) || ((step_fcode == F_SLL) && step_v);

  always_comb begin
    code_n         = '0;
    code_n[CODE_S] = step_out[WIDTH-1];
    code_n[CODE_Z] = (step_out == '0);
    code_n[CODE_C] = c_new;
    code_n[CODE_V] = v_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fcode_q    <= '0;
      rem        <= '0;
      work       <= '0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      resp_valid <= 1'b0;
      code       <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fcode_q <= req_fcode;
            err     <= !is_legal(req_fcode);
            if (!is_legal(req_fcode)) begin
              work       <= req_in;
              code       <= '0;
              resp_valid <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: ;
      endcase
      if (advance) begin
        work <= step_out;
        rem  <= rem_next;
        c_q  <= c_new;
        v_q  <= v_new;
        if (rem_next == '0) begin
          code       <= code_n;
          resp_valid <= 1'b1;
          state      <= DONE;
        end else begin
          state <= RUN;
        end
      end
    end
  end

endmodule
